// File: rtl/wb_master_pkg.sv
// Shared types for the IO Wishbone master bridge: FSM states, response causes
// and the constant classic-cycle tags driven on cti/bte.
package wb_master_pkg;

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_e;

  typedef enum logic [2:0] {OK, BUS_ERR, RTY_EXH, TIMEOUT, MISALIGN} cause_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  function automatic logic cause_is_err(input cause_e cause);
    return cause != OK;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts enabled cycles and flags expiry on the last allowed cycle;
// the count saturates there instead of wrapping.
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (enable_i && (timer_q != LAST)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired_o = enable_i && (timer_q == LAST);

endmodule

// File: rtl/wb_io_master.sv
// Valid/ready core port to classic Wishbone master with watchdog, bounded retry
// and misalignment rejection; every accepted request yields one response pulse.
module wb_io_master
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_e        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  cause_e        cause;
  logic          wd_expired;

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clear_i  (state_q != BUS),
    .enable_i (state_q == BUS),
    .expired_o(wd_expired)
  );

  // Ready is masked during reset so nothing is accepted while the bridge is held.
  assign req_ready_o = (state_q == IDLE) && !wb_rst_i;

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cause       = OK;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          if (req_addr_i[1:0] != 2'b00) begin
            state_d = RESP;
            cause   = MISALIGN;
          end else begin
            state_d = BUS;
            adr_d   = {req_addr_i[31:2], 2'b00};
            dat_d   = req_wdata_i;
            sel_d   = req_be_i;
            we_d    = req_we_i;
          end
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          state_d = RESP;
          if (!we_q) rsp_rdata_d = wbm_dat_i;
        end else if (wbm_err_i) begin
          state_d = RESP;
          cause   = BUS_ERR;
        end else if (wbm_rty_i) begin
          if (retry_q < RETRY_LIMIT) begin
            state_d = BACKOFF;
            retry_d = retry_q + RW'(1);
          end else begin
            state_d = RESP;
            cause   = RTY_EXH;
          end
        end else if (wd_expired) begin
          state_d = RESP;
          cause   = TIMEOUT;
        end
      end
      BACKOFF: state_d = BUS;
      RESP: begin
        state_d = IDLE;
        retry_d = '0;
      end
      default: state_d = IDLE;
    endcase
    cyc_d       = (state_d == BUS);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = (state_d == RESP) && cause_is_err(cause);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_we_o    = we_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_cti_o   = CTI_CLASSIC;
  assign wbm_bte_o   = BTE_LINEAR;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_wb_io_master.sv
// Scoreboard bench for wb_io_master: the driver plays core and slave, pushes the
// expected response; a monitor pops and compares on every rsp_valid pulse.
module tb_wb_io_master;

  localparam int TO = 255;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err, rty;
  logic [2:0]  cti;
  logic [1:0]  bte;

  always #5 clk = ~clk;

  wb_io_master #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   rsp_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("cyc_low_at_rsp", 64'(cyc), 64'(0));
        end
        rsp_seen++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  // kind: 0 ack, 1 err, 2 ack+err together, 3 no answer (timeout)
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [3:0] t_be, input logic [31:0] rd, input int n_rty,
                         input int kind, input int dly);
    exp_t e;
    int   target;
    int   cnt;
    int   n_send;
    logic final_rsp;
    target = rsp_seen + 1;
    if (t_addr[1:0] != 2'b00)        e = '{1'b1, 32'h0};
    else if (n_rty > MR)             e = '{1'b1, 32'h0};
    else if (kind == 1 || kind == 3) e = '{1'b1, 32'h0};
    else                             e = '{1'b0, t_we ? 32'h0 : rd};
    exp_q.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_we = t_we; req_addr = t_addr; req_wdata = t_wdata; req_be = t_be;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("req_ready_wait", 64'(cnt < 20), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;

    if (t_addr[1:0] != 2'b00) begin
      for (int i = 0; i < 4; i++) begin
        chk("misalign_no_cyc", 64'(cyc), 64'(0));
        @(negedge clk);
      end
    end else begin
      n_send = (n_rty > MR) ? MR + 1 : n_rty;
      for (int a = 0; a <= n_send; a++) begin
        if (a == n_send && n_rty > MR) break;
        cnt = 0;
        while (stb !== 1'b1 && cnt < 10) begin @(negedge clk); cnt++; end
        if (a == 0) chk("stb_latency", 64'(cnt), 64'(0));
        else        chk("backoff_gap", 64'(cnt), 64'(1));
        chk("bus_adr", 64'(adr), 64'(t_addr));
        chk("bus_sel_we", 64'({sel, we, cti, bte}), 64'({t_be, t_we, 3'b000, 2'b00}));
        if (t_we) chk("bus_dat", 64'(dat_o), 64'(t_wdata));
        final_rsp = (a == n_send) || (n_rty > MR && a == n_send - 1);
        if (a == n_send && kind == 3) begin
          cnt = 0;
          while (stb === 1'b1 && cnt < 400) begin cnt++; @(negedge clk); end
          chk("timeout_stb_cycles", 64'(cnt), 64'(TO));
          chk("rsp_after_timeout", 64'(rsp_valid), 64'(1));
        end else begin
          repeat (dly) begin
            @(negedge clk);
            chk("stb_hold", 64'({cyc, stb}), 64'(2'b11));
          end
          if (a < n_send) rty = 1'b1;
          else begin
            ack = (kind != 1);
            err = (kind != 0);
            dat_i = rd;
          end
          @(negedge clk);
          ack = 1'b0; err = 1'b0; rty = 1'b0; dat_i = $urandom;
          if (final_rsp) chk("rsp_timing", 64'(rsp_valid), 64'(1));
          else           chk("backoff_cyc_low", 64'(cyc), 64'(0));
        end
      end
    end
    cnt = 0;
    while (rsp_seen < target && cnt < 20) begin @(negedge clk); cnt++; end
    chk("rsp_arrived", 64'(rsp_seen >= target), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    logic        r_we;
    logic [31:0] r_addr;
    int          r_kind, r_rty;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    dat_i = '0; ack = 1'b0; err = 1'b0; rty = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'(1));
    chk("reset_cyc_stb", 64'({cyc, stb}), 64'(0));
    chk("reset_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    chk("reset_bus_regs", 64'({adr, sel, we}), 64'(0));

    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 0, 1);
    run_txn(1'b1, 32'h0000_0020, 32'h0000_00A5, 4'b0001, 32'h1234_5678, 0, 0, 0);
    run_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 32'hCAFE_0001, 3, 0, 0);
    run_txn(1'b0, 32'h0000_0034, 32'h0, 4'hF, 32'hCAFE_0002, 4, 0, 0);
    run_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'hCAFE_0003, 0, 3, 0);
    run_txn(1'b0, 32'h0000_0042, 32'h0, 4'hF, 32'hCAFE_0004, 0, 0, 0);
    run_txn(1'b0, 32'h0000_0050, 32'h0, 4'hF, 32'h0BAD_F00D, 0, 2, 0);
    run_txn(1'b1, 32'h0000_0060, 32'h5555_AAAA, 4'hC, 32'h0, 0, 1, 2);

    // Reset while the bridge holds a bus cycle with no slave answer.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0070; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_cyc", 64'(cyc), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_cyc", 64'({cyc, stb}), 64'(0));
    chk("reset_mid_rsp", 64'(rsp_valid), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mid_ready", 64'(req_ready), 64'(1));

    for (int i = 0; i < 40; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      if ($urandom_range(0, 5) != 0) r_addr[1:0] = 2'b00;
      r_kind = ($urandom_range(0, 14) == 0) ? 3 : int'($urandom_range(0, 2));
      r_rty  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 0;
      run_txn(r_we, r_addr, $urandom, 4'($urandom_range(0, 15)), $urandom,
              r_rty, r_kind, int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
